// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: load a block of words, odd-even transposition sort with one compare-exchange per cycle, stream out ascending
module sort_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int PW        = $clog2(DEPTH);
    localparam int LAST_PASS = (DEPTH == 2) ? 0 : DEPTH - 1;

    generate
        if (DEPTH < 2 || DEPTH % 2 != 0) begin : g_bad_depth
            $error("sort_seq_ctrl: DEPTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t                state, nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_idx, rd_idx, p, k, lo, hi;
    logic                  last_pair, done;

    // pair k of pass p sits at 2k (even pass) or 2k+1 (odd pass); odd passes hold one pair fewer
    assign lo        = PW'({k, p[0]});
    assign hi        = lo + 1'b1;
    assign last_pair = k == (p[0] ? PW'(DEPTH/2 - 2) : PW'(DEPTH/2 - 1));
    assign done      = last_pair && p == PW'(LAST_PASS);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= nxt;
    end

    // next state and stream outputs
    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = state != LOAD;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                nxt      = (in_valid && wr_idx == PW'(DEPTH - 1)) ? SORT : LOAD;
            end
            SORT: nxt = done ? DRAIN : SORT;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = mem[rd_idx];
                out_last  = rd_idx == PW'(DEPTH - 1);
                nxt       = (out_ready && out_last) ? LOAD : DRAIN;
            end
            default: nxt = LOAD;
        endcase
    end

    // write, read, pass and pair counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            p      <= '0;
            k      <= '0;
        end else begin
            if (state == LOAD && in_valid)
                wr_idx <= (wr_idx == PW'(DEPTH - 1)) ? '0 : wr_idx + 1'b1;
            if (state == SORT) begin
                k <= last_pair ? '0 : k + 1'b1;
                p <= last_pair ? (done ? '0 : p + 1'b1) : p;
            end
            if (state == DRAIN && out_ready)
                rd_idx <= out_last ? '0 : rd_idx + 1'b1;
        end
    end

    // word storage: load writes and the shared compare-exchange; equal words never swap
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem[wr_idx] <= in_data;
        end else if (state == SORT && mem[lo] > mem[hi]) begin
            mem[lo] <= mem[hi];
            mem[hi] <= mem[lo];
        end
    end
endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb_sort_seq_ctrl: directed checks of load, sort latency, ordered drain, backpressure, reset and DEPTH=2
module tb_sort_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid, out_last, busy;
    logic [7:0] out_data;
    logic       in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [7:0] in_data2 = 8'h00;
    logic       in_ready2, out_valid2, out_last2, busy2;
    logic [7:0] out_data2;
    logic [7:0] vin [8];
    logic [7:0] vexp [8];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    sort_seq_ctrl #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    sort_seq_ctrl #(.DATA_WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2), .busy(busy2)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_last, busy, out_data} !== {4'b1000, 8'h00}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b ov=%b last=%b busy=%b data=%h want 1 0 0 0 00",
                     in_ready, out_valid, out_last, busy, out_data);
        end
        total++;
        if ({in_ready2, out_valid2, busy2} !== 3'b100) begin
            bad++;
            $display("FAIL reset_state_d2: got rdy=%b ov=%b busy=%b want 1 0 0", in_ready2, out_valid2, busy2);
        end
        rst = 1'b0;
    endtask

    task automatic load(input bit gap);
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = (i % 2 == 0) ? 8'h00 : 8'hFF;
            end
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_ready[%0d]: got %b want 1", i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = vin[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_sort();
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL sort_flags: got rdy=%b busy=%b want 0 1", in_ready, busy);
            end
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 28) begin
            bad++;
            $display("FAIL sort_cycles: got %0d want 28", n);
        end
    endtask

    task automatic drain(input bit bp, input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 100) begin
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            total++;
            if (out_valid !== 1'b1 || out_data !== vexp[got] || out_last !== (got == 7)) begin
                bad++;
                $display("FAIL drain[%0d]: got ov=%b data=%h last=%b want 1 %h %b",
                         got, out_valid, out_data, out_last, vexp[got], got == 7);
            end
            if (out_ready) got++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL drain_count: got %0d want %0d", got, n);
        end
        if (n == 8) begin
            total++;
            if (cyc != (bp ? 22 : 8)) begin
                bad++;
                $display("FAIL drain_cycles: got %0d want %0d", cyc, bp ? 22 : 8);
            end
            total++;
            if ({in_ready, out_valid, busy} !== 3'b100) begin
                bad++;
                $display("FAIL after_drain: got rdy=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
            end
        end
    endtask

    task automatic test_ascending();
        vin  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load(1'b0);
        wait_sort();
        drain(1'b0, 8);
    endtask

    task automatic test_back_to_back_extremes();
        vin  = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F};
        vexp = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF};
        load(1'b0);
        wait_sort();
        drain(1'b0, 8);
    endtask

    task automatic test_backpressure();
        vin  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load(1'b0);
        wait_sort();
        drain(1'b1, 8);
    endtask

    task automatic test_gapped();
        vin  = '{8'd50, 8'd20, 8'd90, 8'd10, 8'd70, 8'd30, 8'd80, 8'd60};
        vexp = '{8'd10, 8'd20, 8'd30, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        load(1'b1);
        wait_sort();
        drain(1'b0, 8);
    endtask

    task automatic check_after_reset(input string tag);
        total++;
        if ({in_ready, out_valid, busy, out_last} !== 4'b1000) begin
            bad++;
            $display("FAIL %s: got rdy=%b ov=%b busy=%b last=%b want 1 0 0 0", tag, in_ready, out_valid, busy, out_last);
        end
    endtask

    task automatic fresh_load();
        vin  = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd5, 8'd6, 8'd4};
        vexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        load(1'b0);
        wait_sort();
        drain(1'b0, 8);
    endtask

    task automatic test_reset_sort();
        vin = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load(1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_after_reset("reset_in_sort");
        fresh_load();
    endtask

    task automatic test_reset_drain();
        vin  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load(1'b0);
        wait_sort();
        drain(1'b0, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_after_reset("reset_in_drain");
        @(negedge clk);
        check_after_reset("reset_in_drain_hold");
        fresh_load();
    endtask

    task automatic depth2_case(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid2 = 1'b1;
        in_data2  = a;
        @(negedge clk);
        in_data2 = b;
        @(negedge clk);
        in_valid2 = 1'b0;
        in_data2  = 8'h00;
        total++;
        if ({out_valid2, busy2, in_ready2} !== 3'b010) begin
            bad++;
            $display("FAIL d2_sort: got ov=%b busy=%b rdy=%b want 0 1 0", out_valid2, busy2, in_ready2);
        end
        @(negedge clk);
        total++;
        if ({out_valid2, out_last2, out_data2} !== {2'b10, 8'd4}) begin
            bad++;
            $display("FAIL d2_first: got ov=%b last=%b data=%0d want 1 0 4", out_valid2, out_last2, out_data2);
        end
        @(negedge clk);
        total++;
        if ({out_valid2, out_last2, out_data2} !== {2'b11, 8'd9}) begin
            bad++;
            $display("FAIL d2_second: got ov=%b last=%b data=%0d want 1 1 9", out_valid2, out_last2, out_data2);
        end
        @(negedge clk);
        total++;
        if ({in_ready2, out_valid2, busy2} !== 3'b100) begin
            bad++;
            $display("FAIL d2_after: got rdy=%b ov=%b busy=%b want 1 0 0", in_ready2, out_valid2, busy2);
        end
    endtask

    task automatic test_depth2();
        depth2_case(8'd9, 8'd4);
        depth2_case(8'd4, 8'd9);
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_back_to_back_extremes();
        test_backpressure();
        test_gapped();
        test_reset_sort();
        test_reset_drain();
        test_depth2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
